// File: rtl/commit_trace_buffer.sv
// Instruction-commit trace buffer: tags each captured commit with a sequence number and
// holds records in a ring, read out first-word-fall-through over a valid/ready stream.
module commit_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SEQ_WIDTH  = 16,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic                     i_clear,
  input  logic                     i_commit_valid,
  input  logic [DATA_WIDTH-1:0]    i_commit_pc,
  input  logic [31:0]              i_commit_instr,
  input  logic [4:0]               i_commit_rd,
  input  logic                     i_commit_rd_we,
  input  logic [DATA_WIDTH-1:0]    i_commit_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [SEQ_WIDTH-1:0]     o_rd_seq,
  output logic [DATA_WIDTH-1:0]    o_rd_pc,
  output logic [31:0]              o_rd_instr,
  output logic [4:0]               o_rd_rd,
  output logic                     o_rd_rd_we,
  output logic [DATA_WIDTH-1:0]    o_rd_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [OVF_WIDTH-1:0]     o_overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]  seq;
    logic [DATA_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  rd_we;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  rec_t                 mem [DEPTH];
  rec_t                 rd_rec;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [SEQ_WIDTH-1:0] seq;
  logic [OVF_WIDTH-1:0] ovf;

  logic capture, pop, is_full, is_empty, wr_en, overwrite, rd_adv, ovf_inc, flush;

  function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
    return (&v) ? v : v + OVF_WIDTH'(1);
  endfunction

  always_comb begin
    flush     = i_reset || i_clear;
    is_full   = (count == CW'(DEPTH));
    is_empty  = (count == '0);
    capture   = i_enable && i_commit_valid;
    pop       = !is_empty && i_rd_ready;
    // A full buffer still accepts the write if a pop frees a slot or wrap mode overwrites.
    wr_en     = capture && (!is_full || pop || i_mode);
    overwrite = capture && is_full && !pop && i_mode;
    rd_adv    = pop || overwrite;
    ovf_inc   = capture && is_full && !pop;
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
      ovf    <= '0;
    end else begin
      if (capture) seq <= seq + SEQ_WIDTH'(1);
      if (ovf_inc) ovf <= sat_inc(ovf);
      if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv)  rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_adv)      count <= count + CW'(1);
      else if (!wr_en && rd_adv) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= '{seq: seq, pc: i_commit_pc, instr: i_commit_instr, rd: i_commit_rd,
                       rd_we: i_commit_rd_we, data: i_commit_rd_data};
    end
  end

  always_comb begin
    rd_rec         = mem[rd_ptr];
    o_rd_valid     = !is_empty;
    o_rd_seq       = rd_rec.seq;
    o_rd_pc        = rd_rec.pc;
    o_rd_instr     = rd_rec.instr;
    o_rd_rd        = rd_rec.rd;
    o_rd_rd_we     = rd_rec.rd_we;
    o_rd_rd_data   = rd_rec.data;
    o_count        = count;
    o_full         = is_full;
    o_empty        = is_empty;
    o_overflow_cnt = ovf;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a queue-based model predicts the buffer contents,
// a negedge monitor compares every presented record and the status outputs against it.
module tb_commit_trace_buffer;
  localparam int DW = 32, DEPTH = 4, SW = 16, OW = 8, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset = 1'b1, i_enable = 1'b1, i_mode = 1'b0, i_clear = 1'b0;
  logic          i_commit_valid = 1'b0, i_commit_rd_we = 1'b0, i_rd_ready = 1'b0;
  logic [DW-1:0] i_commit_pc = '0, i_commit_rd_data = '0;
  logic [31:0]   i_commit_instr = '0;
  logic [4:0]    i_commit_rd = '0;
  logic          o_rd_valid, o_rd_rd_we, o_full, o_empty;
  logic [SW-1:0] o_rd_seq;
  logic [DW-1:0] o_rd_pc, o_rd_rd_data;
  logic [31:0]   o_rd_instr;
  logic [4:0]    o_rd_rd;
  logic [CW-1:0] o_count;
  logic [OW-1:0] o_overflow_cnt;

  commit_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SEQ_WIDTH(SW), .OVF_WIDTH(OW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_mode(i_mode), .i_clear(i_clear),
    .i_commit_valid(i_commit_valid), .i_commit_pc(i_commit_pc), .i_commit_instr(i_commit_instr),
    .i_commit_rd(i_commit_rd), .i_commit_rd_we(i_commit_rd_we), .i_commit_rd_data(i_commit_rd_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_seq(o_rd_seq), .o_rd_pc(o_rd_pc),
    .o_rd_instr(o_rd_instr), .o_rd_rd(o_rd_rd), .o_rd_rd_we(o_rd_rd_we), .o_rd_rd_data(o_rd_rd_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_overflow_cnt(o_overflow_cnt)
  );

  typedef struct {
    logic [SW-1:0] seq;
    logic [DW-1:0] pc;
    logic [31:0]   instr;
    logic [4:0]    rd;
    logic          we;
    logic [DW-1:0] data;
  } rec_t;

  rec_t          exp_q[$];
  logic [SW-1:0] m_seq = '0;
  logic [OW-1:0] m_ovf = '0;
  int            n_cmp = 0, n_bad = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: a bounded queue of records, oldest at the front.
  task automatic model_step();
    rec_t r;
    bit   do_pop;
    if (i_reset || i_clear) begin
      exp_q.delete();
      m_seq = '0;
      m_ovf = '0;
      return;
    end
    do_pop = (exp_q.size() != 0) && i_rd_ready;
    if (do_pop) void'(exp_q.pop_front());
    if (i_enable && i_commit_valid) begin
      r = '{seq: m_seq, pc: i_commit_pc, instr: i_commit_instr, rd: i_commit_rd,
            we: i_commit_rd_we, data: i_commit_rd_data};
      m_seq = m_seq + 1;
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else begin
        if (i_mode) begin
          void'(exp_q.pop_front());
          exp_q.push_back(r);
        end
        if (m_ovf != 8'hFF) m_ovf = m_ovf + 1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 128'(o_count), 128'(exp_q.size()));
      chk("empty", 128'(o_empty), 128'(exp_q.size() == 0));
      chk("full", 128'(o_full), 128'(exp_q.size() == DEPTH));
      chk("valid", 128'(o_rd_valid), 128'(exp_q.size() != 0));
      chk("overflow", 128'(o_overflow_cnt), 128'(m_ovf));
      if (o_rd_valid && exp_q.size() != 0)
        chk("record", {o_rd_seq, o_rd_pc, o_rd_instr, o_rd_rd, o_rd_rd_we, o_rd_rd_data},
            {exp_q[0].seq, exp_q[0].pc, exp_q[0].instr, exp_q[0].rd, exp_q[0].we, exp_q[0].data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [DW-1:0] pc);
    i_commit_valid   = 1'b1;
    i_commit_pc      = pc;
    i_commit_instr   = $urandom;
    i_commit_rd      = 5'($urandom);
    i_commit_rd_we   = 1'($urandom);
    i_commit_rd_data = $urandom;
    tick();
    i_commit_valid = 1'b0;
  endtask

  task automatic drain();
    i_rd_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    i_rd_ready = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    i_reset = 1'b0;
    chk_en  = 1'b1;
    chk("rst_empty", 128'(o_empty), 128'(1));
    chk("rst_count", 128'(o_count), 128'(0));

    // Three commits, then read out in order
    for (int i = 0; i < 3; i++) commit(32'(4 * i));
    chk("three_count", 128'(o_count), 128'(3));
    chk("three_seq", 128'(o_rd_seq), 128'(0));
    chk("three_pc", 128'(o_rd_pc), 128'(0));
    drain();

    // Stop-on-full: two dropped, next capture tagged seq 6
    do_clear();
    i_mode = 1'b0;
    for (int i = 0; i < 6; i++) commit(32'(4 * i));
    chk("m0_ovf", 128'(o_overflow_cnt), 128'(2));
    chk("m0_oldest_pc", 128'(o_rd_pc), 128'(0));
    drain();
    commit(32'h100);
    chk("m0_next_seq", 128'(o_rd_seq), 128'(6));
    drain();

    // Wrap: newest four retained
    do_clear();
    i_mode = 1'b1;
    for (int i = 0; i < 6; i++) commit(32'(4 * i));
    chk("m1_ovf", 128'(o_overflow_cnt), 128'(2));
    chk("m1_oldest_pc", 128'(o_rd_pc), 128'(8));
    chk("m1_oldest_seq", 128'(o_rd_seq), 128'(2));
    drain();

    // Full in stop mode with simultaneous commit and pop
    do_clear();
    i_mode = 1'b0;
    for (int i = 0; i < 4; i++) commit(32'(4 * i));
    i_rd_ready = 1'b1;
    commit(32'h40);
    i_rd_ready = 1'b0;
    chk("fullpop_count", 128'(o_count), 128'(4));
    chk("fullpop_ovf", 128'(o_overflow_cnt), 128'(0));
    chk("fullpop_pc", 128'(o_rd_pc), 128'(4));
    drain();

    // Disabled commits are ignored
    do_clear();
    i_enable = 1'b0;
    commit(32'h10);
    commit(32'h20);
    i_enable = 1'b1;
    i_commit_valid = 1'b1; i_commit_pc = 32'h48; i_commit_instr = 32'h00A00A13;
    i_commit_rd = 5'd20; i_commit_rd_we = 1'b1; i_commit_rd_data = 32'h14;
    tick();
    i_commit_valid = 1'b0;
    chk("en_count", 128'(o_count), 128'(1));
    chk("en_seq", 128'(o_rd_seq), 128'(0));
    chk("en_fields", {o_rd_pc, o_rd_rd, o_rd_rd_we, o_rd_rd_data},
        {32'h48, 5'd20, 1'b1, 32'h14});
    drain();

    // Reset mid-burst with a same-cycle commit
    i_mode = 1'b1;
    for (int i = 0; i < 6; i++) commit(32'(8 * i));
    i_reset = 1'b1;
    commit(32'hDEAD);
    i_reset = 1'b0;
    chk("midrst_count", 128'(o_count), 128'(0));
    chk("midrst_ovf", 128'(o_overflow_cnt), 128'(0));
    commit(32'h200);
    chk("midrst_seq", 128'(o_rd_seq), 128'(0));
    drain();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      i_enable         = ($urandom_range(7) != 0);
      i_commit_valid   = 1'($urandom);
      i_commit_pc      = $urandom;
      i_commit_instr   = $urandom;
      i_commit_rd      = 5'($urandom);
      i_commit_rd_we   = 1'($urandom);
      i_commit_rd_data = $urandom;
      i_rd_ready       = ($urandom_range(2) == 0);
      i_clear          = ($urandom_range(499) == 0);
      if ($urandom_range(99) == 0) i_mode = ~i_mode;
      tick();
    end
    i_commit_valid = 1'b0; i_clear = 1'b0; i_enable = 1'b1;
    drain();

    // Overflow saturation
    do_clear();
    i_mode = 1'b0;
    for (int i = 0; i < 304; i++) commit(32'(i));
    chk("ovf_sat", 128'(o_overflow_cnt), 128'(255));
    i_mode = 1'b1;
    commit(32'h300);
    chk("ovf_sat_wrap", 128'(o_overflow_cnt), 128'(255));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Parametrised hardware capture buffer for instruction-commit records from the CPU datapath (PC, instruction word, destination register write).
- Each record is tagged with a free-running sequence number, so commit gaps are visible after overflow.
- Read out over a valid/ready stream by a debug port or on-chip checker.
- Supports stop-on-full and wrap (ring, keep newest) capture modes, with an overflow counter.

Parameters:
- DATA_WIDTH, 32, width of PC and rd data.
- DEPTH, 16, number of record entries; power of two, >= 2.
- SEQ_WIDTH, 16, width of sequence tag (wraps modulo 2^SEQ_WIDTH).
- OVF_WIDTH, 8, width of overflow counter (saturating).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  capture enable; when 0, commits are ignored and the sequence counter does not advance.
- i_mode  in  1  0 = stop-on-full, 1 = wrap; sampled every cycle.
- i_clear  in  1  synchronous clear of buffer, sequence counter and overflow counter.
- i_commit_valid  in  1  one instruction committed this cycle.
- i_commit_pc  in  DATA_WIDTH  PC of committed instruction.
- i_commit_instr  in  32  instruction word.
- i_commit_rd  in  5  destination register index.
- i_commit_rd_we  in  1  register write performed.
- i_commit_rd_data  in  DATA_WIDTH  value written.
- o_rd_valid  out  1  oldest record available.
- i_rd_ready  in  1  consumer accepts the record.
- o_rd_seq  out  SEQ_WIDTH  sequence tag of the oldest record.
- o_rd_pc, o_rd_instr, o_rd_rd, o_rd_rd_we, o_rd_rd_data  out  as inputs  fields of the oldest record.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_overflow_cnt  out  OVF_WIDTH  dropped/overwritten records, saturating at all-ones.

Behaviour:
- Reset (i_reset=1 at clock edge): pointers = 0, count = 0, seq counter = 0, overflow = 0, o_rd_valid = 0, o_empty = 1, o_full = 0. Memory contents are don't-care.
- i_clear has identical effect to reset and takes priority over a same-cycle commit or pop.
- Storage: DEPTH-entry register array with write and read pointers of $clog2(DEPTH) bits; pointers wrap naturally.
- Capture event: i_enable && i_commit_valid.
  - On each capture event the seq counter increments, whether or not the record is stored.
  - The stored tag is the pre-increment value.
- Read interface is first-word-fall-through.
  - o_rd_valid = !o_empty; fields driven combinationally from the entry at the read pointer.
  - Pop occurs when o_rd_valid && i_rd_ready.
  - Fields are stable while valid && !ready.
- Capture latency: a record captured at edge N is visible on the read port after edge N (o_rd_valid high in cycle N+1 if previously empty).
- Not full: write at write pointer, advance it, count+1 (or unchanged on a simultaneous pop).
- Full, mode 0 (stop-on-full):
  - Without a pop, the record is dropped; overflow+1.
  - With a simultaneous pop, the write is accepted and count stays DEPTH.
- Full, mode 1 (wrap):
  - Without a pop, the oldest entry is overwritten; write and read pointers both advance; count stays DEPTH; overflow+1.
  - With a simultaneous pop, the pop is honoured, the write is accepted, and there is no overflow.
- Empty with a simultaneous capture and i_rd_ready: no pop (o_rd_valid was 0); the record is stored.
- Overflow counter saturates; it never wraps.
- Mode change takes effect on the next capture event; buffer contents are retained.
- A pop while i_enable = 0 is permitted.

Test Plan:
- Reset then 3 commits (PC 0x0, 0x4, 0x8), ready = 0 → count = 3, o_rd_seq = 0, o_rd_pc = 0x0; pop 3 → PCs 0x0/0x4/0x8 with seq 0/1/2, then o_empty = 1.
- DEPTH = 4, mode 0, 6 commits PC 0x00..0x14, no reads → count = 4, overflow = 2, readout PCs 0x00..0x0C with seq 0..3; the next commit is tagged seq 6.
- DEPTH = 4, mode 1, 6 commits as above → overflow = 2, readout PCs 0x08, 0x0C, 0x10, 0x14 with seq 2..5.
- Full in mode 0, commit and pop in the same cycle → count stays 4, overflow unchanged; the popped record is the oldest, and the new record appears last.
- i_enable = 0 during 2 commits, then 1 commit with PC 0x48, rd = 20, rd_we = 1, data 0x14 → count = 1, seq = 0, all fields match.
- Assert i_reset (or i_clear) mid-burst with commit valid in the same cycle → count = 0, overflow = 0, next capture tagged seq 0; drive 300 overflows with OVF_WIDTH = 8 → counter saturates at 255.
